ext_mem_loader: RTL and testbench
=================================

Name: ext_mem_loader

Overview:
- Parametrised boot/test loader and data-memory bus arbiter between the external test port and the riscv_cpu data port.
- Holds the CPU in reset and accepts a burst of words over a valid/ready stream, writing them to auto-incrementing addresses.
- Releases the CPU when the burst completes; after release, passes CPU stores through unchanged.
- Adds burst length, handshake, completion/error reporting and boot-hold mode to the plain reset-gated write mux.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, address width.
- LEN_W, 8, burst-length counter width; max burst is 2^LEN_W-1 words.
- STRIDE, 4, address increment per accepted word.
- BOOT_HOLD, 1, 1 = leave reset in HOLD (CPU held); 0 = leave reset in RUN.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- ld_start  in  1  single-cycle burst request.
- ld_base  in  ADDR_W  first write address, sampled with ld_start.
- ld_len  in  LEN_W  word count, sampled with ld_start.
- ld_valid  in  1  stream word valid.
- ld_data  in  DATA_W  stream word.
- ld_ready  out  1  loader accepts a word.
- cpu_memwrite  in  1  CPU store strobe.
- cpu_adr  in  ADDR_W  CPU data address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_storesrc  in  2  CPU store size.
- mem_we  out  1  data-memory write enable.
- mem_adr  out  ADDR_W  data-memory address.
- mem_wdata  out  DATA_W  data-memory write data.
- mem_storesrc  out  2  data-memory store size.
- cpu_hold  out  1  CPU reset request; 1 = CPU held.
- ld_busy  out  1  burst in progress.
- ld_done  out  1  one-cycle pulse on burst completion.
- ld_err  out  1  one-cycle pulse when ld_start is rejected.
- ld_count  out  LEN_W  words accepted in the current or last burst.

Behaviour:

States and reset values:
- States: HOLD, LOAD, RELEASE, RUN.
- Reset goes to HOLD if BOOT_HOLD=1, else RUN.
- Reset values: mem_we=0, ld_ready=0, ld_done=0, ld_err=0, ld_busy=0, ld_count=0, cpu_hold=BOOT_HOLD, internal address register=0, pending-write flag=0.

Per-state behaviour:
- HOLD: cpu_hold=1, mem_we=0, ld_ready=0. ld_start latches base/len, clears ld_count, and moves to LOAD.
- RUN: cpu_hold=0. mem_* = cpu_* combinationally. ld_start moves to LOAD; cpu_hold rises in the next cycle and any CPU store in that start cycle still completes.
- LOAD: cpu_hold=1, ld_busy=1, ld_ready=1 while ld_count<len.
  - Handshake (ld_valid&ld_ready) registers {addr, ld_data} as a pending write; addr+=STRIDE; ld_count++.
  - Pending write drives mem_we=1, mem_adr, mem_wdata, mem_storesrc=ST_WORD exactly one cycle after its handshake (latency 1); back-to-back beats give one write per cycle.
  - When ld_count reaches len (including len=0 on entry), ld_ready drops the same cycle and the state goes to RELEASE.
- RELEASE (one cycle): drives the pending final write, if any, pulses ld_done, keeps cpu_hold=1. Next state is RUN; cpu_hold=0 from the following cycle.

Arbitration:
- In LOAD/RELEASE, CPU bus inputs are ignored and cpu_memwrite never reaches mem_we.

Boundary rules:
- Address arithmetic wraps modulo 2^ADDR_W.
- ld_len=0: no writes; LOAD lasts one cycle; ld_done pulses in RELEASE.
- ld_start in LOAD or RELEASE: ignored, ld_err pulses one cycle, burst unaffected.
- ld_valid outside LOAD: ignored, ld_ready=0.
- ld_valid deasserted mid-burst: LOAD waits indefinitely; no timeout.
- reset low mid-burst: next cycle is the reset state, no pending write issued, ld_count=0.
- Simultaneous reset low and ld_start: reset wins.

Decomposition:
- Shared package rv_mem_pkg holds:
  - state enum (HOLD, LOAD, RELEASE, RUN);
  - store-size constants ST_BYTE=2'b00, ST_HALF=2'b01, ST_WORD=2'b10 (shared with data_mem and riscv_cpu);
  - default DATA_W/ADDR_W.
- One natural sub-module: ld_write_stage, the one-entry pending-write register with address incrementer and counter.
- The arbiter mux stays in the top module.

Test Plan:
1. BOOT_HOLD=1, reset released, then ld_start base=0x100 len=3, data 0xAA,0xBB,0xCC on consecutive cycles:
   - writes to 0x100, 0x104, 0x108, each one cycle after its handshake;
   - ld_done in the cycle of the 0x108 write, cpu_hold=0 the next cycle, ld_count=3.
2. Same burst with ld_valid low for 2 cycles between beats:
   - ld_ready stays 1 and no spurious mem_we;
   - addresses and data identical to scenario 1.
3. ld_len=0:
   - mem_we never asserts;
   - ld_done pulses 2 cycles after ld_start;
   - cpu_hold falls 3 cycles after ld_start.
4. ld_start during LOAD:
   - ld_err pulses 1 cycle;
   - original burst completes with its original base and len.
5. Reset low after 2 of 4 beats:
   - mem_we=0 from the reset cycle onward;
   - state HOLD, ld_count=0, cpu_hold=1.
6. RUN with cpu_memwrite=1, cpu_adr=0x20, cpu_wdata=0x55, cpu_storesrc=ST_BYTE:
   - mem_* mirror the CPU inputs in the same cycle.
   - Then burst base=0xFFFFFFFC len=2: writes to 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/rv_mem_pkg.sv
`default_nettype none
// ============================================================
// Package : rv_mem_pkg
// Brief   : loader state encoding and data-memory store sizes
// Rev     : 1.0
// ============================================================
package rv_mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;

    // Store-size codes shared with data_mem and riscv_cpu
    localparam logic [1:0] ST_BYTE = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_WORD = 2'b10;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } ld_state_e;

endpackage
`default_nettype wire

// File: rtl/ld_write_stage.sv
`default_nettype none
// ============================================================
// Module : ld_write_stage
// Brief  : one-entry pending write with address stepper and beat counter
// Rev    : 1.0
// ============================================================
module ld_write_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8,
    parameter int STRIDE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic              beat,
    input  logic [DATA_W-1:0] data,
    output logic [LEN_W-1:0]  count,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_adr,
    output logic [DATA_W-1:0] pend_wdata
);

    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [LEN_W-1:0]  count_q,      count_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_adr_q,   pend_adr_d;
    logic [DATA_W-1:0] pend_wdata_q, pend_wdata_d;

    always_comb begin
        addr_d       = addr_q;
        count_d      = count_q;
        pend_valid_d = beat;
        pend_adr_d   = pend_adr_q;
        pend_wdata_d = pend_wdata_q;
        if (start) begin
            addr_d  = base;
            count_d = '0;
        end else if (beat) begin
            pend_adr_d   = addr_q;
            pend_wdata_d = data;
            // Wraps modulo 2^ADDR_W by construction
            addr_d       = addr_q + ADDR_W'(STRIDE);
            count_d      = count_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q       <= '0;
            count_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_adr_q   <= '0;
            pend_wdata_q <= '0;
        end else begin
            addr_q       <= addr_d;
            count_q      <= count_d;
            pend_valid_q <= pend_valid_d;
            pend_adr_q   <= pend_adr_d;
            pend_wdata_q <= pend_wdata_d;
        end
    end

    assign count      = count_q;
    assign pend_valid = pend_valid_q;
    assign pend_adr   = pend_adr_q;
    assign pend_wdata = pend_wdata_q;

endmodule
`default_nettype wire

// File: rtl/ext_mem_loader.sv
`default_nettype none
// ============================================================
// Module : ext_mem_loader
// Brief  : burst boot loader and data-memory write arbiter
// Rev    : 1.0
// ============================================================
module ext_mem_loader
    import rv_mem_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int LEN_W     = 8,
    parameter int STRIDE    = 4,
    parameter int BOOT_HOLD = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [LEN_W-1:0]  ld_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              cpu_memwrite,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_storesrc,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_storesrc,
    output logic              cpu_hold,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err,
    output logic [LEN_W-1:0]  ld_count
);

    localparam ld_state_e RESET_STATE = (BOOT_HOLD != 0) ? HOLD : RUN;

    ld_state_e         state_q, state_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic              err_q,   err_d;

    logic              start_ok;
    logic              beat;
    logic [LEN_W-1:0]  count;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_adr;
    logic [DATA_W-1:0] pend_wdata;

    assign start_ok = ld_start && (state_q == HOLD || state_q == RUN);
    assign beat     = ld_valid && ld_ready;

    ld_write_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W),
        .STRIDE (STRIDE)
    ) u_write_stage (
        .clk        (clk),
        .reset      (reset),
        .start      (start_ok),
        .base       (ld_base),
        .beat       (beat),
        .data       (ld_data),
        .count      (count),
        .pend_valid (pend_valid),
        .pend_adr   (pend_adr),
        .pend_wdata (pend_wdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RESET_STATE;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        err_d   = ld_start && (state_q == LOAD || state_q == RELEASE);
        if (start_ok) begin
            len_d = ld_len;
        end
        case (state_q)
            HOLD:    if (ld_start) state_d = LOAD;
            RUN:     if (ld_start) state_d = LOAD;
            // Leave on the final handshake so the last write lands in RELEASE
            LOAD:    if (count == len_q || (beat && (count + LEN_W'(1)) == len_q))
                         state_d = RELEASE;
            RELEASE: state_d = RUN;
            default: state_d = RESET_STATE;
        endcase
    end

    always_comb begin
        ld_ready     = (state_q == LOAD) && (count < len_q);
        ld_busy      = (state_q == LOAD);
        ld_done      = (state_q == RELEASE);
        ld_err       = err_q;
        ld_count     = count;
        cpu_hold     = (state_q != RUN);
        mem_we       = 1'b0;
        mem_adr      = pend_adr;
        mem_wdata    = pend_wdata;
        mem_storesrc = ST_WORD;
        case (state_q)
            RUN: begin
                mem_we       = cpu_memwrite;
                mem_adr      = cpu_adr;
                mem_wdata    = cpu_wdata;
                mem_storesrc = cpu_storesrc;
            end
            LOAD, RELEASE: mem_we = pend_valid;
            default:       mem_we = 1'b0;
        endcase
        // A pending beat must not reach memory in the cycle reset is asserted
        mem_we = mem_we && reset;
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_loader.sv
`default_nettype none
// ============================================================
// Module : tb_ext_mem_loader
// Brief  : directed self-checking bench for ext_mem_loader
// Rev    : 1.0
// ============================================================
module tb_ext_mem_loader;
    import rv_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_start;
    logic [31:0] ld_base;
    logic [7:0]  ld_len;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        cpu_memwrite;
    logic [31:0] cpu_adr;
    logic [31:0] cpu_wdata;
    logic [1:0]  cpu_storesrc;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_storesrc;
    logic        cpu_hold;
    logic        ld_busy;
    logic        ld_done;
    logic        ld_err;
    logic [7:0]  ld_count;

    int n_chk  = 0;
    int n_fail = 0;

    ext_mem_loader #(
        .DATA_W(32), .ADDR_W(32), .LEN_W(8), .STRIDE(4), .BOOT_HOLD(1)
    ) dut (
        .clk(clk), .reset(reset),
        .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_storesrc(cpu_storesrc),
        .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_storesrc(mem_storesrc),
        .cpu_hold(cpu_hold), .ld_busy(ld_busy), .ld_done(ld_done),
        .ld_err(ld_err), .ld_count(ld_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_start = 0; ld_base = '0; ld_len = '0; ld_valid = 0; ld_data = '0;
        cpu_memwrite = 0; cpu_adr = '0; cpu_wdata = '0; cpu_storesrc = ST_WORD;
    endtask

    task automatic test_reset();
        reset = 0;
        idle_inputs();
        repeat (3) step();
        #1;
        n_chk++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL rst_hold got=%0b exp=1", cpu_hold); end
        n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got=%0b exp=0", mem_we); end
        n_chk++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%0b exp=0", ld_ready); end
        n_chk++; if ({ld_done, ld_err, ld_busy} !== 3'b000) begin n_fail++; $display("FAIL rst_flags got=%b exp=000", {ld_done, ld_err, ld_busy}); end
        n_chk++; if (ld_count !== 8'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", ld_count); end
        reset = 1;
    endtask

    task automatic test_burst();
        step(); ld_start = 1; ld_base = 32'h100; ld_len = 8'd3; #1;
        n_chk++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL b1_hold0 got=%0b exp=1", cpu_hold); end
        step(); ld_start = 0; ld_valid = 1; ld_data = 32'hAA; #1;
        n_chk++; if ({ld_ready, ld_busy, mem_we} !== 3'b110) begin n_fail++; $display("FAIL b1_c1 rdy/busy/we got=%b exp=110", {ld_ready, ld_busy, mem_we}); end
        step(); ld_data = 32'hBB; #1;
        n_chk++; if ({mem_we, mem_adr, mem_wdata} !== {1'b1, 32'h100, 32'hAA}) begin n_fail++; $display("FAIL b1_w0 got=%0b/%h/%h exp=1/00000100/000000aa", mem_we, mem_adr, mem_wdata); end
        n_chk++; if (mem_storesrc !== ST_WORD) begin n_fail++; $display("FAIL b1_size got=%b exp=10", mem_storesrc); end
        step(); ld_data = 32'hCC; #1;
        n_chk++; if ({mem_we, mem_adr, mem_wdata} !== {1'b1, 32'h104, 32'hBB}) begin n_fail++; $display("FAIL b1_w1 got=%0b/%h/%h exp=1/00000104/000000bb", mem_we, mem_adr, mem_wdata); end
        step(); ld_valid = 0; #1;
        n_chk++; if ({mem_we, mem_adr, mem_wdata} !== {1'b1, 32'h108, 32'hCC}) begin n_fail++; $display("FAIL b1_w2 got=%0b/%h/%h exp=1/00000108/000000cc", mem_we, mem_adr, mem_wdata); end
        n_chk++; if ({ld_done, ld_ready, cpu_hold} !== 3'b101) begin n_fail++; $display("FAIL b1_release done/rdy/hold got=%b exp=101", {ld_done, ld_ready, cpu_hold}); end
        n_chk++; if (ld_count !== 8'd3) begin n_fail++; $display("FAIL b1_count got=%0d exp=3", ld_count); end
        step(); #1;
        n_chk++; if ({cpu_hold, ld_done, mem_we} !== 3'b000) begin n_fail++; $display("FAIL b1_run hold/done/we got=%b exp=000", {cpu_hold, ld_done, mem_we}); end
    endtask

    task automatic test_gapped();
        bit          v_pat [8] = '{1, 0, 0, 1, 0, 0, 1, 0};
        bit          we_pat[8] = '{0, 1, 0, 0, 1, 0, 0, 1};
        logic [31:0] dat[3] = '{32'hAA, 32'hBB, 32'hCC};
        logic [31:0] adr[3] = '{32'h100, 32'h104, 32'h108};
        int nb = 0;
        int nw = 0;
        step(); ld_start = 1; ld_base = 32'h100; ld_len = 8'd3; #1;
        for (int i = 0; i < 8; i++) begin
            step();
            ld_start = 0;
            ld_valid = v_pat[i];
            ld_data  = v_pat[i] ? dat[nb] : 32'hDEAD_BEEF;
            if (v_pat[i]) nb++;
            // CPU tries to store during the burst; must be ignored
            cpu_memwrite = 1; cpu_adr = 32'h40; cpu_wdata = 32'h77; cpu_storesrc = ST_BYTE;
            #1;
            n_chk++; if (mem_we !== we_pat[i]) begin n_fail++; $display("FAIL gap_we[%0d] got=%0b exp=%0b", i, mem_we, we_pat[i]); end
            n_chk++; if (ld_ready !== (i != 7)) begin n_fail++; $display("FAIL gap_ready[%0d] got=%0b exp=%0b", i, ld_ready, (i != 7)); end
            if (we_pat[i]) begin
                n_chk++; if ({mem_adr, mem_wdata, mem_storesrc} !== {adr[nw], dat[nw], ST_WORD}) begin n_fail++; $display("FAIL gap_wr[%0d] got=%h/%h/%b exp=%h/%h/10", nw, mem_adr, mem_wdata, mem_storesrc, adr[nw], dat[nw]); end
                nw++;
            end
        end
        n_chk++; if (ld_done !== 1'b1) begin n_fail++; $display("FAIL gap_done got=%0b exp=1", ld_done); end
        step(); cpu_memwrite = 0; ld_valid = 0; #1;
        n_chk++; if (cpu_hold !== 1'b0) begin n_fail++; $display("FAIL gap_hold got=%0b exp=0", cpu_hold); end
    endtask

    task automatic test_len_zero();
        step(); ld_start = 1; ld_base = 32'h500; ld_len = 8'd0; ld_valid = 1; ld_data = 32'h99; #1;
        step(); ld_start = 0; #1;
        n_chk++; if ({ld_busy, ld_ready, mem_we, cpu_hold} !== 4'b1001) begin n_fail++; $display("FAIL z_c1 busy/rdy/we/hold got=%b exp=1001", {ld_busy, ld_ready, mem_we, cpu_hold}); end
        step(); #1;
        n_chk++; if ({ld_done, mem_we, cpu_hold} !== 3'b101) begin n_fail++; $display("FAIL z_c2 done/we/hold got=%b exp=101", {ld_done, mem_we, cpu_hold}); end
        step(); ld_valid = 0; #1;
        n_chk++; if ({ld_done, mem_we, cpu_hold} !== 3'b000) begin n_fail++; $display("FAIL z_c3 done/we/hold got=%b exp=000", {ld_done, mem_we, cpu_hold}); end
        n_chk++; if (ld_count !== 8'd0) begin n_fail++; $display("FAIL z_count got=%0d exp=0", ld_count); end
    endtask

    task automatic test_start_in_load();
        step(); ld_start = 1; ld_base = 32'h200; ld_len = 8'd2; #1;
        step(); ld_start = 1; ld_base = 32'h300; ld_len = 8'd5; ld_valid = 1; ld_data = 32'h11; #1;
        n_chk++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL e_c1 err got=%0b exp=0", ld_err); end
        step(); ld_start = 0; ld_data = 32'h22; #1;
        n_chk++; if (ld_err !== 1'b1) begin n_fail++; $display("FAIL e_c2 err got=%0b exp=1", ld_err); end
        n_chk++; if ({mem_we, mem_adr, mem_wdata} !== {1'b1, 32'h200, 32'h11}) begin n_fail++; $display("FAIL e_w0 got=%0b/%h/%h exp=1/00000200/00000011", mem_we, mem_adr, mem_wdata); end
        step(); ld_valid = 0; #1;
        n_chk++; if (ld_err !== 1'b0) begin n_fail++; $display("FAIL e_c3 err got=%0b exp=0", ld_err); end
        n_chk++; if ({mem_we, mem_adr, mem_wdata, ld_done} !== {1'b1, 32'h204, 32'h22, 1'b1}) begin n_fail++; $display("FAIL e_w1 got=%0b/%h/%h done=%0b exp=1/00000204/00000022 done=1", mem_we, mem_adr, mem_wdata, ld_done); end
        step(); #1;
        n_chk++; if ({cpu_hold, ld_count} !== {1'b0, 8'd2}) begin n_fail++; $display("FAIL e_end hold=%0b count=%0d exp hold=0 count=2", cpu_hold, ld_count); end
    endtask

    task automatic test_reset_mid_burst();
        step(); ld_start = 1; ld_base = 32'h400; ld_len = 8'd4; #1;
        step(); ld_start = 0; ld_valid = 1; ld_data = 32'hE1; #1;
        step(); ld_data = 32'hE2; #1;
        n_chk++; if ({mem_we, mem_adr} !== {1'b1, 32'h400}) begin n_fail++; $display("FAIL r_w0 got=%0b/%h exp=1/00000400", mem_we, mem_adr); end
        step(); reset = 0; ld_data = 32'hE3; #1;
        n_chk++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL r_rstcyc_we got=%0b exp=0", mem_we); end
        step(); reset = 1; ld_valid = 0; #1;
        n_chk++; if ({mem_we, cpu_hold, ld_ready, ld_busy} !== 4'b0100) begin n_fail++; $display("FAIL r_after we/hold/rdy/busy got=%b exp=0100", {mem_we, cpu_hold, ld_ready, ld_busy}); end
        n_chk++; if (ld_count !== 8'd0) begin n_fail++; $display("FAIL r_count got=%0d exp=0", ld_count); end
        step(); #1;
        n_chk++; if ({mem_we, cpu_hold} !== 2'b01) begin n_fail++; $display("FAIL r_hold2 we/hold got=%b exp=01", {mem_we, cpu_hold}); end
    endtask

    task automatic test_run_and_wrap();
        // Empty burst takes the loader from HOLD to RUN
        step(); ld_start = 1; ld_len = 8'd0; #1;
        step(); ld_start = 0; #1;
        step(); #1;
        step(); cpu_memwrite = 1; cpu_adr = 32'h20; cpu_wdata = 32'h55; cpu_storesrc = ST_BYTE; #1;
        n_chk++; if ({mem_we, mem_adr, mem_wdata, mem_storesrc} !== {1'b1, 32'h20, 32'h55, ST_BYTE}) begin n_fail++; $display("FAIL p_run got=%0b/%h/%h/%b exp=1/00000020/00000055/00", mem_we, mem_adr, mem_wdata, mem_storesrc); end
        step(); ld_start = 1; ld_base = 32'hFFFF_FFFC; ld_len = 8'd2; cpu_adr = 32'h24; #1;
        n_chk++; if ({mem_we, mem_adr, cpu_hold} !== {1'b1, 32'h24, 1'b0}) begin n_fail++; $display("FAIL p_startcyc got=%0b/%h hold=%0b exp=1/00000024 hold=0", mem_we, mem_adr, cpu_hold); end
        step(); ld_start = 0; ld_valid = 1; ld_data = 32'hF1; #1;
        n_chk++; if ({mem_we, cpu_hold} !== 2'b01) begin n_fail++; $display("FAIL p_c1 we/hold got=%b exp=01", {mem_we, cpu_hold}); end
        step(); ld_data = 32'hF2; #1;
        n_chk++; if ({mem_we, mem_adr, mem_wdata} !== {1'b1, 32'hFFFF_FFFC, 32'hF1}) begin n_fail++; $display("FAIL p_w0 got=%0b/%h/%h exp=1/fffffffc/000000f1", mem_we, mem_adr, mem_wdata); end
        step(); ld_valid = 0; #1;
        n_chk++; if ({mem_we, mem_adr, mem_wdata, ld_done} !== {1'b1, 32'h0, 32'hF2, 1'b1}) begin n_fail++; $display("FAIL p_w1 got=%0b/%h/%h done=%0b exp=1/00000000/000000f2 done=1", mem_we, mem_adr, mem_wdata, ld_done); end
        step(); cpu_memwrite = 0; #1;
        n_chk++; if ({cpu_hold, mem_we} !== 2'b00) begin n_fail++; $display("FAIL p_end hold/we got=%b exp=00", {cpu_hold, mem_we}); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_gapped();
        test_len_zero();
        test_start_in_load();
        test_reset_mid_burst();
        test_run_and_wrap();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
